// File: rtl/shift_iter_pkg.sv
// Shared definitions for the iterative shifter: shift-type codes and FSM states.
package shift_iter_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  localparam int unsigned NUM_STAGES = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_iter_stage.sv
// Single fixed-amount shifter stage with enable bypass; bit 1 of fun selects arithmetic right.
module shift_stage
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [1:0]       fun,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    // NOTE: default assignment first so every path drives dout and no latch is inferred.
    dout = din;
    if (en) begin
      if (fun[1]) begin
        dout = WIDTH'($signed(din) >>> AMT);
      end else if (fun == SHIFT_SRL) begin
        dout = din >> AMT;
      end else begin
        dout = din << AMT;
      end
    end
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle shifter: one binary-weighted stage (16,8,4,2,1) per cycle, done pulse on completion.
module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  input  logic [1:0]       ALUfun,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       k_q;
  logic [4:0]       shamt_q;
  logic [1:0]       fun_q;
  logic             accept;
  logic [WIDTH-1:0] stage_out [NUM_STAGES];
  logic [WIDTH-1:0] acc_next;

  // Stage i shifts by 2^i and is enabled by the matching latched shamt bit.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << i)) u_stage (
      .din  (acc_q),
      .en   (shamt_q[i]),
      .fun  (fun_q),
      .dout (stage_out[i])
    );
  end

  always_comb begin
    acc_next = acc_q;
    case (k_q)
      3'd0:    acc_next = stage_out[0];
      3'd1:    acc_next = stage_out[1];
      3'd2:    acc_next = stage_out[2];
      3'd3:    acc_next = stage_out[3];
      3'd4:    acc_next = stage_out[4];
      default: acc_next = acc_q;
    endcase
  end

  assign accept = start && (state_q != S_SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (k_q == 3'd0) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= 3'd4;
      shamt_q <= '0;
      fun_q   <= SHIFT_SLL;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q   <= B;
        shamt_q <= shamt;
        fun_q   <= ALUfun;
        k_q     <= 3'd4;
      end else if (state_q == S_SHIFT) begin
        acc_q <= acc_next;
        k_q   <= k_q - 3'd1;
      end
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign y    = acc_q;

endmodule

// File: tb/tb_shift_iter.sv
// Directed bench for shift_iter: latency, shift types, ignored/back-to-back starts, async reset, sweep.
module tb_shift_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] B = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  ALUfun = 2'b00;
  logic        busy, done;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;

  shift_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .B      (B),
    .shamt  (shamt),
    .ALUfun (ALUfun),
    .busy   (busy),
    .done   (done),
    .y      (y)
  );

  always #5 clk = ~clk;

  // Drive a request at a falling edge; returns at the falling edge after the accepting edge.
  task automatic accept(input logic [31:0] b, input logic [4:0] s, input logic [1:0] f);
    @(negedge clk);
    B = b; shamt = s; ALUfun = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges from just after acceptance until done; bounded at 20.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [4:0] s,
                                            input logic [1:0] f);
    if (f[1]) return 32'($signed(b) >>> s);
    if (f[0]) return b >> s;
    return b << s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (y !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: y=%h busy=%b done=%b, want y=0 busy=0 done=0", y, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sll_latency();
    accept(32'h0000_0001, 5'd31, 2'b00);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL sll_busy[%0d]: busy=%b done=%b, want busy=1 done=0", c, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || y !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll_done: done=%b busy=%b y=%h, want 1 0 80000000", done, busy, y);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || y !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll_hold: done=%b y=%h, want done=0 y=80000000", done, y);
    end
  endtask

  task automatic test_types();
    logic [1:0]  funs [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [31:0] exps [4] = '{32'hF800_0000, 32'h0800_0000, 32'hF800_0000, 32'h0000_0000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      accept(32'h8000_0000, 5'd4, funs[i]);
      wait_done(cyc);
      checks++;
      if (cyc != 5 || y !== exps[i]) begin
        errors++;
        $display("FAIL type_%b: cycles=%0d y=%h, want 5 %h", funs[i], cyc, y, exps[i]);
      end
    end
  endtask

  task automatic test_shamt_zero();
    int cyc;
    accept(32'hDEAD_BEEF, 5'd0, 2'b00);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || y !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL shamt_zero: cycles=%0d y=%h, want 5 deadbeef", cyc, y);
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    accept(32'hF000_0000, 5'd8, 2'b01);
    @(negedge clk);
    B = 32'h1234_5678; shamt = 5'd3; ALUfun = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 3 || y !== 32'h00F0_0000) begin
      errors++;
      $display("FAIL ignored_start: remaining=%0d y=%h, want 3 00f00000", cyc, y);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    accept(32'h0000_00FF, 5'd8, 2'b00);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || y !== 32'h0000_FF00) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d y=%h, want 5 0000ff00", cyc, y);
    end
    B = 32'h8000_0001; shamt = 5'd1; ALUfun = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 5 || y !== 32'hC000_0000) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d y=%h, want 5 c0000000", cyc, y);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    accept(32'h0000_0F0F, 5'd4, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: y=%h busy=%b done=%b, want 0 0 0", y, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: done pulse seen=%b, want 0", seen);
    end
    accept(32'h0000_0F0F, 5'd4, 2'b00);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || y !== 32'h0000_F0F0) begin
      errors++;
      $display("FAIL reset_recover: cycles=%0d y=%h, want 5 0000f0f0", cyc, y);
    end
  endtask

  task automatic test_sweep();
    int cyc;
    logic [31:0] b, expv;
    logic [4:0]  s;
    logic [1:0]  f;
    for (int i = 0; i < 1000; i++) begin
      b = $urandom();
      s = 5'($urandom_range(0, 31));
      f = 2'($urandom_range(0, 3));
      expv = ref_shift(b, s, f);
      accept(b, s, f);
      wait_done(cyc);
      checks++;
      if (cyc != 5 || y !== expv) begin
        errors++;
        $display("FAIL sweep[%0d] b=%h s=%0d f=%b: cycles=%0d y=%h, want 5 %h",
                 i, b, s, f, cyc, y, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll_latency();
    test_types();
    test_shamt_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
